// File: rtl/ibex_instr_mem_responder.sv
// Memory-side responder for the Ibex instruction fetch port: grants pipelined reads to a
// single-port SRAM and returns in-order responses at a fixed latency. Optional macro:
// IBEX_INSTR_RESP_RANGE_CHECK_EN (out-of-range requests answered with an error, no SRAM access).
module ibex_instr_mem_responder #(
  parameter int unsigned MemWords       = 1024,
  parameter logic [31:0] BaseAddr       = 32'h0000_0000,
  parameter int unsigned Latency        = 1,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        instr_req_i,
  output logic                        instr_gnt_o,
  input  logic [31:0]                 instr_addr_i,
  output logic                        instr_rvalid_o,
  output logic [31:0]                 instr_rdata_o,
  output logic                        instr_err_o,
  input  logic                        stall_i,
  output logic                        mem_req_o,
  output logic [$clog2(MemWords)-1:0] mem_addr_o,
  input  logic [31:0]                 mem_rdata_i,
  output logic                        busy_o
);

  localparam int unsigned AW = $clog2(MemWords);
  localparam int unsigned CW = $clog2(MaxOutstanding + 1);
  localparam logic [CW-1:0] MaxCnt = CW'(MaxOutstanding);

  logic [CW-1:0]      r_cnt;
  logic [Latency-1:0] r_valid;
  logic               w_gnt;
  logic               w_rvalid;
  logic               w_err;
  logic               w_inRange;
  logic [31:0]        w_data;

  assign w_rvalid = r_valid[Latency-1];

  // A slot freed by this cycle's rvalid can be handed out again immediately.
  assign w_gnt = rst_ni & instr_req_i & ~stall_i & ((r_cnt < MaxCnt) | w_rvalid);

`ifdef IBEX_INSTR_RESP_RANGE_CHECK_EN
  localparam logic [32:0] RangeBytes = 33'(MemWords) << 2;

  logic [31:0]        w_offset;
  logic [Latency-1:0] r_err;

  assign w_offset  = instr_addr_i - BaseAddr;
  assign w_inRange = ({1'b0, w_offset} < RangeBytes);
  assign w_err     = r_err[Latency-1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_err <= '0;
    end else begin
      r_err[0] <= w_gnt & ~w_inRange;
      for (int i = 1; i < Latency; i++) begin
        r_err[i] <= r_err[i-1];
      end
    end
  end
`else
  logic w_unusedAddr;

  assign w_unusedAddr = ^instr_addr_i;
  assign w_inRange    = 1'b1;
  assign w_err        = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid <= '0;
    end else begin
      r_valid[0] <= w_gnt;
      for (int i = 1; i < Latency; i++) begin
        r_valid[i] <= r_valid[i-1];
      end
    end
  end

  // With a single stage the SRAM output is the response; deeper pipelines carry it along.
  if (Latency == 1) begin : g_directData
    assign w_data = mem_rdata_i;
  end else begin : g_regData
    logic [31:0] r_data [Latency-1:1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int i = 1; i < Latency; i++) begin
          r_data[i] <= '0;
        end
      end else begin
        if (r_valid[0]) begin
          r_data[1] <= mem_rdata_i;
        end
        for (int i = 2; i < Latency; i++) begin
          if (r_valid[i-1]) begin
            r_data[i] <= r_data[i-1];
          end
        end
      end
    end

    assign w_data = r_data[Latency-1];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(w_gnt) - CW'(w_rvalid);
    end
  end

  assign instr_gnt_o    = w_gnt;
  assign mem_req_o      = w_gnt & w_inRange;
  assign mem_addr_o     = instr_addr_i[AW+1:2];
  assign instr_rvalid_o = w_rvalid;
  assign instr_err_o    = w_rvalid & w_err;
  assign instr_rdata_o  = (w_rvalid & ~w_err) ? w_data : 32'h0;
  assign busy_o         = (r_cnt != '0);

  cntBound : assert property (@(posedge clk_i) disable iff (!rst_ni) r_cnt <= MaxCnt);

endmodule

// File: tb/tb_ibex_instr_mem_responder.sv
// Randomized scoreboard bench for ibex_instr_mem_responder: two instances (Latency 1 / 3)
// share one stimulus stream; each has its own reference model, SRAM model and response monitor.
module tb_ibex_instr_mem_responder;

  localparam int MW = 1024;

  typedef struct {
    int          due;
    logic [31:0] data;
    logic        err;
  } resp_t;

  logic        clk = 1'b0;
  logic        rstN;
  logic        req;
  logic [31:0] addr;
  logic        stall;
  int          cycleCnt = 0;
  int          testsRun = 0;
  int          failCount = 0;
  logic [31:0] tbMem [MW];

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input int inst, input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL g%0d.%s at cycle %0d: got %h expected %h", inst, name, cycleCnt,
               actual, expected);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int          L    = (g == 0) ? 1 : 3;
    localparam int          MAXO = (g == 0) ? 1 : 2;
    localparam logic [31:0] BASE = (g == 0) ? 32'h0000_0000 : 32'h8000_0000;

    logic        gnt, rvalid, err, memReq, busy;
    logic [31:0] rdata, sramOut;
    logic [9:0]  memAddr;
    int          inflight[$];
    resp_t       sb[$];

    ibex_instr_mem_responder #(
      .MemWords(MW), .BaseAddr(BASE), .Latency(L), .MaxOutstanding(MAXO)
    ) u_dut (
      .clk_i(clk), .rst_ni(rstN), .instr_req_i(req), .instr_gnt_o(gnt),
      .instr_addr_i(addr), .instr_rvalid_o(rvalid), .instr_rdata_o(rdata),
      .instr_err_o(err), .stall_i(stall), .mem_req_o(memReq), .mem_addr_o(memAddr),
      .mem_rdata_i(sramOut), .busy_o(busy)
    );

    // SRAM: data one cycle after a read, garbage otherwise so unrequested reads show up.
    always @(posedge clk) begin
      if (memReq) sramOut <= tbMem[memAddr];
      else        sramOut <= $urandom;
    end

    // Reference model: outstanding responses are a list of due cycles.
    always @(negedge clk) begin
      logic        expRv, expGnt, inRange, expErr;
      int          idx;
      longint      a;
      if (!rstN) begin
        inflight.delete();
        sb.delete();
        checkOutput(g, "rstGnt", {31'b0, gnt}, 0);
        checkOutput(g, "rstMemReq", {31'b0, memReq}, 0);
        checkOutput(g, "rstBusy", {31'b0, busy}, 0);
      end else begin
        a = longint'(addr);
`ifdef IBEX_INSTR_RESP_RANGE_CHECK_EN
        inRange = (a >= longint'(BASE)) && (a < longint'(BASE) + MW * 4);
`else
        inRange = 1'b1;
`endif
        expErr = !inRange;
        idx    = int'((addr >> 2) % MW);
        expRv  = (inflight.size() > 0) && (inflight[0] == cycleCnt);
        expGnt = req && !stall && ((inflight.size() < MAXO) || expRv);
        checkOutput(g, "busy", {31'b0, busy}, {31'b0, inflight.size() != 0});
        checkOutput(g, "gnt", {31'b0, gnt}, {31'b0, expGnt});
        checkOutput(g, "memReq", {31'b0, memReq}, {31'b0, expGnt && inRange});
        if (expGnt && inRange) checkOutput(g, "memAddr", {22'b0, memAddr}, idx);
        if (expRv) void'(inflight.pop_front());
        if (expGnt) begin
          inflight.push_back(cycleCnt + L);
          sb.push_back('{cycleCnt + L, expErr ? 32'h0 : tbMem[idx], expErr});
        end
      end
    end

    // Monitor: every rvalid must match the oldest expected response, on time.
    always @(negedge clk) begin
      resp_t e;
      if (!rstN) begin
        checkOutput(g, "rstRvalid", {31'b0, rvalid}, 0);
        checkOutput(g, "rstRdata", rdata, 0);
      end else if (rvalid) begin
        if (sb.size() == 0) begin
          checkOutput(g, "unexpectedRvalid", 1, 0);
        end else begin
          e = sb.pop_front();
          checkOutput(g, "rvalidCycle", cycleCnt, e.due);
          checkOutput(g, "rdata", rdata, e.data);
          checkOutput(g, "err", {31'b0, err}, {31'b0, e.err});
        end
      end else begin
        checkOutput(g, "idleRdata", rdata, 0);
        checkOutput(g, "idleErr", {31'b0, err}, 0);
        if (sb.size() > 0 && sb[0].due <= cycleCnt) begin
          checkOutput(g, "missingRvalid", 0, 1);
          void'(sb.pop_front());
        end
      end
    end
  end

  task automatic applyStimulus(input logic r, input logic [31:0] a, input logic s);
    req   = r;
    addr  = a;
    stall = s;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pickAddr();
    case ($urandom % 4)
      0:       return $urandom & 32'h0000_1FFF;
      1:       return 32'h8000_0000 | ($urandom & 32'h0000_1FFF);
      2:       return $urandom;
      default: return $urandom & 32'h0000_0FFF;
    endcase
  endfunction

  initial begin
    rstN  = 1'b0;
    req   = 1'b0;
    addr  = '0;
    stall = 1'b0;
    for (int i = 0; i < MW; i++) tbMem[i] = $urandom;
    tbMem[4]    = 32'hDEAD_BEEF;
    tbMem[1]    = 32'h1234_5678;
    tbMem[1023] = 32'hCAFE_F00D;
    repeat (3) @(posedge clk);
    #1 rstN = 1'b1;

    applyStimulus(1'b1, 32'h0000_0010, 1'b0);
    repeat (4) applyStimulus(1'b0, 32'h0, 1'b0);

    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 32'(i * 4), 1'b0);
    repeat (4) applyStimulus(1'b0, 32'h0, 1'b0);

    repeat (5) applyStimulus(1'b1, 32'h0000_0020, 1'b1);
    applyStimulus(1'b1, 32'h0000_0020, 1'b0);
    repeat (4) applyStimulus(1'b0, 32'h0, 1'b0);

    applyStimulus(1'b1, 32'h8000_1000, 1'b0);
    applyStimulus(1'b1, 32'h8000_0FFC, 1'b0);
    applyStimulus(1'b1, 32'h0000_1004, 1'b0);
    applyStimulus(1'b1, 32'h8000_0FFF, 1'b0);
    repeat (5) applyStimulus(1'b0, 32'h0, 1'b0);

    applyStimulus(1'b1, 32'h0000_0010, 1'b0);
    applyStimulus(1'b1, 32'h0000_0014, 1'b0);
    req  = 1'b0;
    rstN = 1'b0;
    @(posedge clk);
    #1 rstN = 1'b1;
    repeat (5) applyStimulus(1'b0, 32'h0, 1'b0);
    applyStimulus(1'b1, 32'h0000_0010, 1'b0);
    repeat (4) applyStimulus(1'b0, 32'h0, 1'b0);

    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom % 4) != 0, pickAddr(), ($urandom % 5) == 0);
    end
    repeat (8) applyStimulus(1'b0, 32'h0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
